main_memory_responder: RTL and testbench
========================================

// Module: main_memory_responder
// PURPOSE
//   Memory-side responder for the data cache's refill/write-through port. Holds a
//   byte-addressed 64 KiB backing store and serves one 16-bit word request at a time.
//   A request is accepted on a valid/ready handshake, and the response is returned after a
//   fixed, parameterised latency. The response is held until the cache accepts it.
//   Sits between the cache miss/write path and the (modelled) DRAM.
// PARAMETERS
//   ADDR_W         16     byte address width
//   DATA_W         16     word width; must equal 16 (two bytes per access)
//   MEM_BYTES      65536  backing store size in bytes (= 2**ADDR_W)
//   READ_LATENCY   4      edges from request accept to resp_valid for reads (>=1)
//   WRITE_LATENCY  2      edges from request accept to resp_valid for writes (>=1)
// PORTS
//   clk          in   1       system clock, rising edge
//   reset        in   1       asynchronous, active-high reset
//   req_valid    in   1       cache presents a request
//   req_ready    out  1       responder can accept a request this cycle
//   req_write    in   1       1 = write word, 0 = read word
//   req_addr     in   ADDR_W  byte address of low byte
//   req_wdata    in   DATA_W  write data; [7:0] -> addr, [15:8] -> addr+1
//   resp_valid   out  1       response available
//   resp_ready   in   1       cache consumes the response
//   resp_write   out  1       echo of req_write for the response
//   resp_rdata   out  DATA_W  read data {mem[addr+1], mem[addr]}; 0 for writes
// BEHAVIOUR
//   Reset (async assert, sync release):
//     state=IDLE; req_ready=1; resp_valid=0; resp_write=0; resp_rdata=0; counter=0.
//     Backing store contents are NOT cleared. A request in flight is dropped;
//     a write that has not yet committed is discarded.
//   FSM: IDLE -> WAIT -> RESP -> IDLE.
//     IDLE: req_ready=1. Accept on the edge where req_valid&&req_ready.
//       Latch addr, wdata and write. Load counter=LAT-1 (LAT = READ_ or WRITE_LATENCY).
//       If LAT==1, go directly to RESP; otherwise go to WAIT.
//     WAIT: req_ready=0. Decrement counter each edge. Go to RESP on the edge where counter==1.
//     On entering RESP (same edge): commit the write (mem[a]<=wd[7:0], mem[a+1]<=wd[15:8]),
//       or capture resp_rdata={mem[a+1],mem[a]}. Set resp_valid=1.
//       resp_valid therefore rises exactly LAT edges after the accept edge.
//     RESP: resp_valid, resp_write and resp_rdata are held stable until resp_valid&&resp_ready.
//       On that edge: resp_valid=0, resp_rdata=0, go to IDLE.
//       req_ready stays 0 in RESP. The next request can be accepted one cycle after the response handshake.
//   Exactly one outstanding request; no reordering. A read following a write to the
//     same bytes always returns the new data.
//   Address arithmetic: addr+1 is computed modulo 2**ADDR_W, so 0xFFFF pairs with 0x0000.
//     Odd (unaligned) addresses are legal and use the same byte pairing.
//   req_* inputs are ignored outside the accept edge. Changes while req_ready=0 have no effect.
//   resp_ready asserted while resp_valid=0 has no effect.
//   Simultaneous reset and handshake: reset wins; nothing is committed.
// TESTING
//   1. Reset, then write 0xBEEF @0x0010, then read @0x0010.
//      -> Write resp_valid 2 edges after accept. Read resp_rdata=0xBEEF 4 edges after accept.
//   2. Write 0x1234 @0xFFFF, then read @0xFFFF and read @0x0000.
//      -> Reads return 0x1234, then {mem[1],0x12}. Confirms wrap and byte order.
//   3. Hold resp_ready=0 for 10 cycles after a read.
//      -> resp_valid and resp_rdata stay stable, req_ready=0 throughout. Then handshake -> IDLE.
//   4. Hold req_valid=1 continuously with back-to-back reads of 0x0020 and 0x0021.
//      -> Second accept is 1 cycle after the first response handshake. Data is byte-shifted correctly.
//   5. Assert reset during WAIT of a write of 0xAAAA @0x0040 (mem was 0x5555).
//      -> Outputs return to reset values. A subsequent read @0x0040 returns 0x5555.
//   6. Odd address: write 0xCAFE @0x0101, then read @0x0100.
//      -> Low byte of the read is the prior mem[0x100]; high byte is 0xFE.

Source files
------------

// File: rtl/main_memory_responder_if.sv
// Cache <-> main-memory request/response bus (master = cache, slave = memory).
// Latency: none, wires only.
// Backpressure: req_valid/req_ready on the request path, resp_valid/resp_ready on the response path.
interface main_memory_responder_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic              resp_write;
   logic [DATA_W-1:0] resp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_write, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_write, resp_rdata
   );
endinterface

// File: rtl/main_memory_responder.sv
// Purpose: 64 KiB byte-addressed backing store answering one 16-bit word request at a time.
// Latency: resp_valid rises LAT edges after accept, counting the accept edge (LAT = READ_/WRITE_LATENCY).
// Backpressure: single outstanding request; req_ready low until the response is taken on resp_ready.
module main_memory_responder #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 16,
   parameter int MEM_BYTES     = 65536,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 2
) (
   input logic                    i_clk,
   input logic                    i_reset,
   main_memory_responder_if.slave io_bus
);
   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam int HALF    = MEM_BYTES / 2;
   localparam int IDX_W   = ADDR_W - 1;
   localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WRITE_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_accept;
   logic              w_enter_resp;
   logic              w_resp_done;

   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_write;
   logic              r_resp_write;
   logic [DATA_W-1:0] r_rdata;

   // Store is split into even/odd byte banks so a word access (aligned or not)
   // touches each bank exactly once and needs only one write port per bank.
   logic [7:0]        r_mem_even [HALF];
   logic [7:0]        r_mem_odd  [HALF];

   logic              w_op_write;
   logic [ADDR_W-1:0] w_op_addr;
   logic [DATA_W-1:0] w_op_wdata;
   logic [IDX_W-1:0]  w_lo_idx;
   logic [IDX_W-1:0]  w_even_idx;
   logic [7:0]        w_even_byte;
   logic [7:0]        w_odd_byte;
   logic [7:0]        w_rd_lo;
   logic [7:0]        w_rd_hi;
   logic [7:0]        w_wr_even;
   logic [7:0]        w_wr_odd;
   logic              w_commit;

   // With LAT==1 the response is produced on the accept edge, so the operand
   // must come straight from the bus rather than from the latched copy.
   assign w_op_write = w_accept ? io_bus.req_write : r_write;
   assign w_op_addr  = w_accept ? io_bus.req_addr  : r_addr;
   assign w_op_wdata = w_accept ? io_bus.req_wdata : r_wdata;

   // Low byte lives in the bank selected by addr[0]; the high byte is in the other
   // bank at index (addr+1)>>1, which wraps 0xFFFF onto byte 0x0000.
   assign w_lo_idx    = w_op_addr[ADDR_W-1:1];
   assign w_even_idx  = w_op_addr[ADDR_W-1:1] + IDX_W'(w_op_addr[0]);
   assign w_even_byte = r_mem_even[w_even_idx];
   assign w_odd_byte  = r_mem_odd[w_lo_idx];
   assign w_rd_lo     = w_op_addr[0] ? w_odd_byte  : w_even_byte;
   assign w_rd_hi     = w_op_addr[0] ? w_even_byte : w_odd_byte;
   assign w_wr_even   = w_op_addr[0] ? w_op_wdata[15:8] : w_op_wdata[7:0];
   assign w_wr_odd    = w_op_addr[0] ? w_op_wdata[7:0]  : w_op_wdata[15:8];

   // Reset on the commit edge wins: the pending write is discarded.
   assign w_commit = w_enter_resp && w_op_write && !i_reset;

   assign io_bus.req_ready  = (r_state == S_IDLE);
   assign io_bus.resp_valid = (r_state == S_RESP);
   assign io_bus.resp_write = r_resp_write;
   assign io_bus.resp_rdata = r_rdata;

   // Next-state and handshake decode for the IDLE -> WAIT -> RESP -> IDLE sequence.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_accept     = 1'b0;
      w_enter_resp = 1'b0;
      w_resp_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.req_valid) begin
               w_accept  = 1'b1;
               w_cnt_nxt = io_bus.req_write ? WR_CNT_INIT : RD_CNT_INIT;
               if (w_cnt_nxt == '0) begin
                  w_enter_resp = 1'b1;
                  w_state_nxt  = S_RESP;
               end else begin
                  w_state_nxt  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_enter_resp = 1'b1;
               w_state_nxt  = S_RESP;
            end
         end
         S_RESP: begin
            if (io_bus.resp_ready) begin
               w_resp_done = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and latency counter registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Request capture and response registers; response is held until handshake.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_addr       <= '0;
         r_wdata      <= '0;
         r_write      <= 1'b0;
         r_resp_write <= 1'b0;
         r_rdata      <= '0;
      end else begin
         if (w_accept) begin
            r_addr  <= io_bus.req_addr;
            r_wdata <= io_bus.req_wdata;
            r_write <= io_bus.req_write;
         end
         if (w_enter_resp) begin
            r_resp_write <= w_op_write;
            r_rdata      <= w_op_write ? '0 : {w_rd_hi, w_rd_lo};
         end else if (w_resp_done) begin
            r_rdata      <= '0;
         end
      end
   end

   // Backing store write port; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (w_commit) begin
         r_mem_even[w_even_idx] <= w_wr_even;
         r_mem_odd[w_lo_idx]    <= w_wr_odd;
      end
   end
endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// transaction-level model of the store and the response timing.
module tb_main_memory_responder;
   localparam int RL = 4;
   localparam int WL = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   cmp_en = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   main_memory_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   main_memory_responder #(
      .ADDR_W(16), .DATA_W(16), .MEM_BYTES(65536),
      .READ_LATENCY(RL), .WRITE_LATENCY(WL)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT (cycle %0d)", nm, cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   // ---------------- transaction-level model ----------------
   // A byte array is the store; an accepted request occupies the port for LAT
   // edges (the accept edge is the first) and then until the response is taken.
   logic [7:0]  m_mem   [65536];
   bit          m_known [65536];
   bit          m_busy  = 1'b0;
   bit          m_resp  = 1'b0;
   bit          m_wr    = 1'b0;
   int          m_n     = 0;
   int          m_lat   = 0;
   logic [15:0] m_addr  = '0;
   logic [15:0] m_wdata = '0;
   logic [15:0] m_rdata = '0;
   logic [15:0] m_rmask = '0;
   bit          m_rwr   = 1'b0;

   task automatic model_complete();
      logic [15:0] a1;
      a1 = m_addr + 16'd1;
      m_resp = 1'b1;
      m_rwr  = m_wr;
      if (m_wr) begin
         m_mem[m_addr] = m_wdata[7:0];
         m_mem[a1]     = m_wdata[15:8];
         m_known[m_addr] = 1'b1;
         m_known[a1]     = 1'b1;
         m_rdata = 16'h0000;
         m_rmask = 16'hFFFF;
      end else begin
         m_rdata = {m_mem[a1], m_mem[m_addr]};
         m_rmask = {m_known[a1] ? 8'hFF : 8'h00, m_known[m_addr] ? 8'hFF : 8'h00};
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_busy  = 1'b0;
         m_resp  = 1'b0;
         m_rdata = '0;
         m_rmask = 16'hFFFF;
      end else if (!m_busy) begin
         if (bus.req_valid) begin
            m_busy  = 1'b1;
            m_wr    = bus.req_write;
            m_addr  = bus.req_addr;
            m_wdata = bus.req_wdata;
            m_lat   = m_wr ? WL : RL;
            m_n     = 1;
            if (m_n == m_lat) model_complete();
         end
      end else if (!m_resp) begin
         m_n++;
         if (m_n == m_lat) model_complete();
      end else if (bus.resp_ready) begin
         m_busy  = 1'b0;
         m_resp  = 1'b0;
         m_rdata = '0;
         m_rmask = 16'hFFFF;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
         chk("resp_valid", 32'(bus.resp_valid), 32'(m_resp));
         if (m_resp) begin
            chk("resp_write", 32'(bus.resp_write), 32'(m_rwr));
            if (m_rmask != 16'h0000)
               chk("resp_rdata", 32'(bus.resp_rdata & m_rmask), 32'(m_rdata & m_rmask));
         end else begin
            chk("resp_rdata_idle", 32'(bus.resp_rdata), 32'(m_rdata));
         end
      end
   end

   // ---------------- driver ----------------
   // Called at posedge+#1; returns at posedge+#1 just after the response handshake.
   task automatic do_req(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                         input int hold, input bit keep, input bit noise,
                         output logic [15:0] rd, output int lat,
                         output int acc_cyc, output int hs_cyc);
      int n;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready) begin
         n++;
         if (n > 64) timeout("accept");
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (!keep) bus.req_valid = 1'b0;
      // Scramble the request fields; they must be ignored while busy.
      bus.req_addr  = 16'($urandom);
      bus.req_wdata = 16'($urandom);
      bus.req_write = 1'($urandom_range(0, 1));
      lat = 1;
      while (!bus.resp_valid) begin
         if (noise) bus.resp_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         lat++;
         if (lat > 64) timeout("resp_valid");
      end
      bus.resp_ready = 1'b0;
      rd = bus.resp_rdata;
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      hs_cyc = cyc;
      bus.resp_ready = 1'b0;
   endtask

   logic [15:0] rd;
   int lat, a1, h1, a2, h2;

   initial begin
      #500000;
      timeout("watchdog");
   end

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_write", 32'(bus.resp_write), 32'd0);
      chk("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cmp_en = 1'b1;

      // 1: write then read back, with latencies
      do_req(1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      chk("t1_wr_lat", 32'(lat), 32'd2);
      chk("t1_wr_rdata", 32'(rd), 32'h0);
      do_req(1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      chk("t1_rd_lat", 32'(lat), 32'd4);
      chk("t1_rd_data", 32'(rd), 32'hBEEF);

      // 2: wrap at top of address space
      do_req(1'b1, 16'h0000, 16'h7700, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      do_req(1'b1, 16'hFFFF, 16'h1234, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      do_req(1'b0, 16'hFFFF, 16'h0000, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      chk("t2_rd_ffff", 32'(rd), 32'h1234);
      do_req(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      chk("t2_rd_0000", 32'(rd), 32'h7712);

      // 3: response held for 10 cycles under backpressure
      do_req(1'b1, 16'h0030, 16'h5A3C, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      do_req(1'b0, 16'h0030, 16'h0000, 10, 1'b0, 1'b0, rd, lat, a1, h1);
      chk("t3_rd_data", 32'(rd), 32'h5A3C);
      chk("t3_idle_ready", 32'(bus.req_ready), 32'd1);

      // 4: back-to-back reads with req_valid held high
      do_req(1'b1, 16'h0020, 16'hB2A1, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      do_req(1'b1, 16'h0022, 16'hD4C3, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      do_req(1'b0, 16'h0020, 16'h0000, 0, 1'b1, 1'b0, rd, lat, a1, h1);
      chk("t4_rd_20", 32'(rd), 32'hB2A1);
      do_req(1'b0, 16'h0021, 16'h0000, 0, 1'b0, 1'b0, rd, lat, a2, h2);
      chk("t4_rd_21", 32'(rd), 32'hC3B2);
      chk("t4_b2b_gap", 32'(a2 - h1), 32'd1);

      // 5: reset during WAIT of a write discards it
      do_req(1'b1, 16'h0040, 16'h5555, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 16'h0040;
      bus.req_wdata = 16'hAAAA;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("t5_wait_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("t5_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("t5_rst_valid", 32'(bus.resp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      // Reset coincident with an acceptable request: reset wins.
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 16'h0040;
      bus.req_wdata = 16'h9999;
      rst = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      do_req(1'b0, 16'h0040, 16'h0000, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      chk("t5_rd_after_rst", 32'(rd), 32'h5555);

      // 6: odd address write, aligned read
      do_req(1'b1, 16'h0100, 16'h1100, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      do_req(1'b1, 16'h0101, 16'hCAFE, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      do_req(1'b0, 16'h0100, 16'h0000, 0, 1'b0, 1'b0, rd, lat, a1, h1);
      chk("t6_rd_100", 32'(rd), 32'hFE00);

      // Randomized traffic over a few hot regions, including the wrap point
      for (int i = 0; i < 300; i++) begin
         bit          wr;
         logic [15:0] addr;
         int          sel;
         wr  = 1'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       addr = 16'h0200 + 16'($urandom_range(0, 15));
            1:       addr = 16'hFFFE + 16'($urandom_range(0, 3));
            2:       addr = 16'h0010 + 16'($urandom_range(0, 3));
            default: addr = 16'($urandom);
         endcase
         do_req(wr, addr, 16'($urandom), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, lat, a1, h1);
         chk("rand_lat", 32'(lat), wr ? 32'(WL) : 32'(RL));
      end
      bus.req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
